complete_queue: RTL

//  Receiving end of the FU completion interface. Accepts at most one completion per cycle

---
 rtl/complete_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/complete_queue.sv
`default_nettype none
// ============================================================================
//  Module      : complete_queue
//  Description : Receiving end of the FU completion interface. Buffers at most
//                one completion per cycle in a circular FIFO and broadcasts
//                the oldest entry on the CDB each cycle. Back-pressures the
//                FU through fu_stall when full; flushed on branch squash.
//  Revision    : 1.0  initial release
// ============================================================================
module complete_queue #(
  parameter int DEPTH = 4,   // FIFO entries, power of two, >= 2
  parameter int PR_W  = 6,   // physical register index width
  parameter int ROB_W = 5,   // ROB index width
  parameter int XLEN  = 32   // data / PC width
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     in_valid,
  input  logic [PR_W-1:0]          in_pr_idx,
  input  logic [ROB_W-1:0]         in_rob_idx,
  input  logic [XLEN-1:0]          in_value,
  input  logic                     in_take_branch,
  input  logic [XLEN-1:0]          in_target_pc,
  output logic                     fu_stall,
  input  logic                     cdb_hold,
  output logic                     cdb_valid,
  output logic [PR_W-1:0]          cdb_pr_idx,
  output logic [ROB_W-1:0]         cdb_rob_idx,
  output logic [XLEN-1:0]          cdb_value,
  output logic                     cdb_take_branch,
  output logic [XLEN-1:0]          cdb_target_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_ENTRY_W = PR_W + ROB_W + XLEN + 1 + XLEN;
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

  // Field offsets inside a packed entry, LSB first:
  // target_pc | take_branch | value | rob_idx | pr_idx
  localparam int c_TB_LSB  = XLEN;
  localparam int c_VAL_LSB = XLEN + 1;
  localparam int c_ROB_LSB = XLEN + 1 + XLEN;
  localparam int c_PR_LSB  = XLEN + 1 + XLEN + ROB_W;

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_PTR_W:0]     r_count;

  logic                 w_full;
  logic                 w_valid;
  logic                 w_push;
  logic                 w_pop;
  logic [c_ENTRY_W-1:0] w_in_entry;
  logic [c_ENTRY_W-1:0] w_head_entry;

  // Full/valid come only from the registered count so no input reaches an output.
  assign w_full  = (r_count == c_FULL);
  assign w_valid = (r_count != '0);

  // A full queue refuses a push even if the head pops in the same cycle;
  // squash kills both sides of the transfer.
  assign w_push = in_valid && !w_full && !squash;
  assign w_pop  = w_valid && !cdb_hold && !squash;

  assign w_in_entry = {in_pr_idx, in_rob_idx, in_value, in_take_branch, in_target_pc};
  assign w_head_entry = r_mem[r_head];

  // Pointer and count bookkeeping; squash empties the queue at the next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= w_in_entry;
    end
  end

  // Head entry broadcast, forced to zero whenever the queue is empty.
  always_comb begin
    cdb_valid       = w_valid;
    cdb_pr_idx      = '0;
    cdb_rob_idx     = '0;
    cdb_value       = '0;
    cdb_take_branch = 1'b0;
    cdb_target_pc   = '0;
    if (w_valid) begin
      cdb_pr_idx      = w_head_entry[c_PR_LSB  +: PR_W];
      cdb_rob_idx     = w_head_entry[c_ROB_LSB +: ROB_W];
      cdb_value       = w_head_entry[c_VAL_LSB +: XLEN];
      cdb_take_branch = w_head_entry[c_TB_LSB];
      cdb_target_pc   = w_head_entry[0 +: XLEN];
    end
  end

  assign fu_stall  = w_full;
  assign occupancy = r_count;

endmodule
`default_nettype wire
